// File: rtl/csoc_pkg.sv
// Shared definitions for the scan dump controller: FSM state encoding and the
// ASCII codes streamed to the UART transmitter.
package csoc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_EMIT,
        ST_NL,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_EOL,
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_NL = 8'h0A;

endpackage

// File: rtl/csoc_clk_gen.sv
// Registered CSoC clock source: a single high cycle on request, or free
// toggling for functional run phases; low otherwise.
module csoc_clk_gen (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    input  logic i_toggle,
    output logic o_csoc_clk
);

    logic r_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_clk <= 1'b0;
        else if (i_pulse)
            r_clk <= 1'b1;
        else if (i_toggle)
            r_clk <= ~r_clk;
        else
            r_clk <= 1'b0;
    end

    assign o_csoc_clk = r_clk;

endmodule

// File: rtl/scan_dump_ctrl.sv
// Scan-snapshot dump controller: shifts the CSoC scan chains and streams every
// captured bit as 'H'/'L' to the UART, with column wrapping and run phases.
module scan_dump_ctrl
    import csoc_pkg::*;
#(
    parameter int NUM_CHAINS    = 1,
    parameter int CHAIN_LEN     = 20,
    parameter int MAX_COL       = 8,
    parameter int RUN_TICKS     = 6,
    parameter int NUM_SNAPSHOTS = 2,
    parameter int LOOPBACK      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  csoc_clk_o,
    output logic                  csoc_rstn_o,
    output logic                  csoc_test_se_o,
    output logic                  csoc_test_tm_o,
    input  logic [NUM_CHAINS-1:0] scan_out_i,
    output logic [NUM_CHAINS-1:0] scan_in_o
);

    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int COL_W  = $clog2(MAX_COL + 1);
    localparam int RUN_W  = $clog2(2 * RUN_TICKS + 1);
    localparam int SNAP_W = $clog2(NUM_SNAPSHOTS + 1);
    localparam int CHAN_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_CHAINS-1:0] r_cap;
    logic [CHAN_W-1:0]     r_chan;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [COL_W-1:0]      r_col;
    logic [RUN_W-1:0]      r_run_cnt;
    logic [SNAP_W-1:0]     r_snap_cnt;
    logic                  r_se_tm;
    logic                  r_rstn;

    logic                  w_xfer;
    logic                  w_last_chan;
    logic                  w_last_bit;
    logic                  w_col_wrap;
    logic                  w_last_snap;
    logic [NUM_CHAINS-1:0] w_cap_sh;
    logic                  w_cur_bit;

    assign w_xfer      = tx_start_o & tx_ready_i;
    assign w_last_chan = (r_chan == CHAN_W'(NUM_CHAINS - 1));
    assign w_last_bit  = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));
    assign w_col_wrap  = (r_col == COL_W'(MAX_COL - 1));
    assign w_last_snap = (r_snap_cnt == SNAP_W'(NUM_SNAPSHOTS - 1));
    assign w_cap_sh    = r_cap >> r_chan;
    assign w_cur_bit   = w_cap_sh[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_start_o  = 1'b0;
        tx_data_o   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (start_i)
                    w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: w_state_nxt = ST_EMIT;
            ST_EMIT: begin
                tx_start_o = 1'b1;
                tx_data_o  = w_cur_bit ? CH_H : CH_L;
                if (w_xfer) begin
                    // The line break at the very end of a snapshot is left to EOL
                    if (w_col_wrap && !(w_last_chan && w_last_bit))
                        w_state_nxt = ST_NL;
                    else if (!w_last_chan)
                        w_state_nxt = ST_EMIT;
                    else
                        w_state_nxt = ST_SHIFT_HI;
                end
            end
            ST_NL: begin
                tx_start_o = 1'b1;
                tx_data_o  = CH_NL;
                if (w_xfer)
                    w_state_nxt = w_last_chan ? ST_SHIFT_HI : ST_EMIT;
            end
            ST_SHIFT_HI: w_state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: begin
                if (r_bit_cnt < BIT_W'(CHAIN_LEN))
                    w_state_nxt = ST_SAMPLE;
                else
                    w_state_nxt = ST_EOL;
            end
            ST_EOL: begin
                tx_start_o = 1'b1;
                tx_data_o  = CH_NL;
                if (w_xfer)
                    w_state_nxt = w_last_snap ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (r_run_cnt == '0)
                    w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: w_state_nxt = ST_SAMPLE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap      <= '0;
            r_chan     <= '0;
            r_bit_cnt  <= '0;
            r_col      <= '0;
            r_run_cnt  <= '0;
            r_snap_cnt <= '0;
            r_se_tm    <= 1'b1;
            r_rstn     <= 1'b0;
        end else begin
            r_rstn  <= 1'b1;
            // Scan enable/test mode drop only for the run phase; SETTLE restores them early
            r_se_tm <= (w_state_nxt != ST_RUN);
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_bit_cnt  <= '0;
                        r_snap_cnt <= '0;
                        r_col      <= '0;
                        r_chan     <= '0;
                    end
                end
                ST_SAMPLE: begin
                    r_cap  <= scan_out_i;
                    r_chan <= '0;
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        r_col <= r_col + COL_W'(1);
                        if (w_state_nxt == ST_EMIT)
                            r_chan <= r_chan + CHAN_W'(1);
                    end
                end
                ST_NL: begin
                    if (w_xfer) begin
                        r_col <= '0;
                        if (w_state_nxt == ST_EMIT)
                            r_chan <= r_chan + CHAN_W'(1);
                    end
                end
                ST_SHIFT_HI: r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                ST_SHIFT_LO: begin
                    if (w_state_nxt == ST_EOL)
                        r_bit_cnt <= '0;
                end
                ST_EOL: begin
                    if (w_xfer) begin
                        r_col <= '0;
                        if (w_state_nxt == ST_RUN) begin
                            r_snap_cnt <= r_snap_cnt + SNAP_W'(1);
                            r_run_cnt  <= RUN_W'(2 * RUN_TICKS - 1);
                        end else begin
                            r_snap_cnt <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_run_cnt != '0)
                        r_run_cnt <= r_run_cnt - RUN_W'(1);
                end
                default: ;
            endcase
        end
    end

    csoc_clk_gen u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_pulse    (w_state_nxt == ST_SHIFT_HI),
        .i_toggle   (w_state_nxt == ST_RUN),
        .o_csoc_clk (csoc_clk_o)
    );

    assign busy_o         = (r_state != ST_IDLE);
    assign done_o         = (r_state == ST_DONE);
    assign csoc_rstn_o    = r_rstn;
    assign csoc_test_se_o = r_se_tm;
    assign csoc_test_tm_o = r_se_tm;
    assign scan_in_o      = (LOOPBACK != 0) ? scan_out_i : '0;

endmodule
